// File: rtl/uart_tx.sv
// uart_tx: baud-tick driven UART transmitter (start, LSB-first data, optional parity, stop bits).
// Define UART_TX_PARITY_EN to insert a parity bit after the data; PARITY_ODD selects its sense.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_send,
  input  logic [7:0] data_in,
  input  logic       baud_en_tx,
  output logic       tx_data_out,
  output logic       tx_active,
  output logic       tx_done
);
  typedef enum logic [2:0] {
    IDLE, SYNC, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t     state_q;
  logic [7:0] sh_q;
  logic [3:0] cnt_q;
  logic [1:0] stop_q;
  logic       tx_q, active_q, done_q;
`ifdef UART_TX_PARITY_EN
  logic       par_q;
`else
  logic       unused_par;
  assign unused_par = PARITY_ODD;
`endif
  assign tx_data_out = tx_q;
  assign tx_active   = active_q;
  assign tx_done     = done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      stop_q   <= '0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // a request landing on the tx_done cycle is still treated as busy
        IDLE: if (tx_send && !done_q) begin
          sh_q     <= data_in;
          active_q <= 1'b1;
          state_q  <= SYNC;
`ifdef UART_TX_PARITY_EN
          par_q    <= (^data_in[DATA_BITS-1:0]) ^ PARITY_ODD;
`endif
        end
        SYNC: if (baud_en_tx) begin
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: if (baud_en_tx) begin
          tx_q    <= sh_q[0];
          sh_q    <= sh_q >> 1;
          cnt_q   <= 4'd1;
          state_q <= DATA;
        end
        DATA: if (baud_en_tx) begin
          if (cnt_q == 4'(DATA_BITS)) begin
`ifdef UART_TX_PARITY_EN
            tx_q    <= par_q;
            state_q <= PARITY;
`else
            tx_q    <= 1'b1;
            stop_q  <= 2'(STOP_BITS - 1);
            state_q <= STOP;
`endif
          end else begin
            tx_q  <= sh_q[0];
            sh_q  <= sh_q >> 1;
            cnt_q <= cnt_q + 4'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (baud_en_tx) begin
          tx_q    <= 1'b1;
          stop_q  <= 2'(STOP_BITS - 1);
          state_q <= STOP;
        end
`endif
        STOP: if (baud_en_tx) begin
          if (stop_q == 2'd0) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            done_q   <= 1'b1;
            cnt_q    <= '0;
          end else begin
            stop_q <= stop_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized bench comparing uart_tx against a frame-array reference model every cycle.
module tb_uart_tx;
  localparam int PERIOD = 869;
  localparam bit PODD   = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int          PB = 1;
  localparam logic [7:0]  D1 = 8'hA5;
  localparam logic [15:0] E1 = 16'h054A | (16'(PODD) << 9);
  localparam logic [15:0] E2 = 16'h05E0 | (16'(PODD) << 9);
`else
  localparam int          PB = 0;
  localparam logic [7:0]  D1 = 8'hAA;
  localparam logic [15:0] E1 = 16'h0354;
  localparam logic [15:0] E2 = 16'h03E0;
`endif
  localparam int FLEN = 1 + 8 + PB + 1;
  logic clk = 0, rst = 1, tx_send = 0, baud_en_tx = 0;
  logic [7:0] data_in = '0;
  logic tx_data_out, tx_active, tx_done;
  int checks = 0, passed = 0;
  bit chk_en = 0;
  int mode = 0, period = PERIOD, tcnt = 0;
  bit man_tick = 0;
  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst(rst), .tx_send(tx_send), .data_in(data_in), .baud_en_tx(baud_en_tx),
    .tx_data_out(tx_data_out), .tx_active(tx_active), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  // reference: a frame is a bit array; each tick advances one position through it
  bit m_busy = 0, m_line = 1, m_done = 0;
  int m_pos = 0;
  bit m_frame [0:15];
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_line <= 1; m_done <= 0;
    end else begin
      m_done <= 0;
      if (!m_busy) begin
        if (tx_send && !m_done) begin
          m_busy <= 1; m_pos <= -1; m_line <= 1;
          m_frame[0] <= 0;
          for (int i = 0; i < 8; i++) m_frame[1+i] <= data_in[i];
`ifdef UART_TX_PARITY_EN
          m_frame[9] <= (^data_in) ^ PODD;
`endif
          m_frame[FLEN-1] <= 1;
        end
      end else if (baud_en_tx) begin
        if (m_pos + 1 < FLEN) begin
          m_pos <= m_pos + 1; m_line <= m_frame[m_pos+1];
        end else begin
          m_busy <= 0; m_done <= 1; m_line <= 1;
        end
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    checks++;
    if ({tx_data_out, tx_active, tx_done} === {m_line, m_busy, m_done}) passed++;
    else if (checks - passed <= 20)
      $display("FAIL cycle_cmp t=%0t dut line/active/done=%b%b%b model=%b%b%b",
               $time, tx_data_out, tx_active, tx_done, m_line, m_busy, m_done);
  end
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s got %h expected %h", name, act, exp);
  endtask
  task automatic step(input bit s, input logic [7:0] d);
    @(posedge clk); #2;
    tx_send = s; data_in = d;
    case (mode)
      0: begin tcnt++; if (tcnt >= period) tcnt = 0; baud_en_tx = (tcnt == 0); end
      1: baud_en_tx = ($urandom_range(3) == 0);
      2: baud_en_tx = 1'b1;
      default: baud_en_tx = man_tick;
    endcase
  endtask
  task automatic send_frame(input logic [7:0] d, input bit inject, output logic [15:0] bits,
                            output logic [15:0] mbits, output int nb, output int act, output int dones);
    int since; bit started, prev;
    bits = '0; mbits = '0; nb = 0; act = 0; dones = 0; since = 0; started = 0;
    step(1, d); prev = 0;
    for (int i = 0; i < 15 * period + 100; i++) begin
      step(inject && i == 5 * period, inject && i == 5 * period ? 8'h55 : 8'($urandom));
      if (prev) begin since = 0; started = 1; end else since++;
      prev = baud_en_tx;
      if (tx_active) act++;
      if (tx_done) dones++;
      if (started && tx_active && since == period / 2 && nb < 16) begin
        bits[nb] = tx_data_out; mbits[nb] = m_line; nb++;
      end
    end
  endtask
  task automatic tick_once();
    man_tick = 1; step(0, 8'h00); man_tick = 0;
  endtask
  initial begin
    logic [15:0] b, mb;
    int nb, act, dn;
    step(0, 8'h00); step(0, 8'h00);
    chk("reset_outputs", {13'b0, tx_data_out, tx_active, tx_done}, 16'h0004);
    rst = 0; chk_en = 1;
    mode = 0;
    repeat (2000) step(0, 8'h00);
    chk("idle_line_high", {15'b0, tx_data_out}, 16'h0001);
    send_frame(D1, 1, b, mb, nb, act, dn);
    chk("frame1_bits", b, E1);
    chk("frame1_model_bits", mb, E1);
    chk("frame1_len", 16'(nb), 16'(FLEN));
    chk("frame1_done_count", 16'(dn), 16'd1);
    chk("frame1_active_time", {15'b0, act > FLEN * period && act <= (FLEN + 1) * period}, 16'd1);
    send_frame(8'hF0, 0, b, mb, nb, act, dn);
    chk("frame2_bits", b, E2);
    chk("frame2_model_bits", mb, E2);
    chk("frame2_done_count", 16'(dn), 16'd1);
    mode = 3;
    man_tick = 1; step(1, 8'h3C); man_tick = 0;
    repeat (3) step(0, 8'h00);
    chk("sync_hold", {14'b0, tx_data_out, tx_active}, 16'h0003);
    tick_once(); step(0, 8'h00);
    chk("start_after_next_tick", {15'b0, tx_data_out}, 16'h0000);
    tick_once(); tick_once(); tick_once(); step(0, 8'h00);
    chk("data_bit2", {15'b0, tx_data_out}, 16'h0001);
    rst = 1; step(0, 8'h00); rst = 0;
    chk("abort_reset", {13'b0, tx_data_out, tx_active, tx_done}, 16'h0004);
    repeat (20) tick_once();
    chk("abort_no_frame", {14'b0, tx_active, tx_done}, 16'h0000);
    mode = 1;
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(15) == 0, 8'($urandom));
      rst = ($urandom_range(999) == 0);
    end
    rst = 0;
    mode = 2;
    repeat (500) step(1, 8'($urandom));
    mode = 0;
    repeat (20) step(0, 8'h00);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
